// File: rtl/mlp_act_pkg.sv
// rtl/mlp_act_pkg.sv - shared types, defaults and address helper for the activation path
package mlp_act_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT_RD = 2'd1,
        PRESENT = 2'd2
    } patch_gather_state_e;

    localparam int DEFAULT_SENSOR_W = 128;
    localparam int DEFAULT_SENSOR_H = 128;
    localparam int DEFAULT_TS_BITS  = 16;

    // Row-major flat address into the timestamp surface.
    function automatic logic [31:0] flat_addr(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/bounds_flatten.sv
// rtl/bounds_flatten.sv - in-frame test and flat address for one neighbour coordinate
module bounds_flatten
    import mlp_act_pkg::*;
#(
    parameter int XY_BITS  = 9,
    parameter int SENSOR_W = DEFAULT_SENSOR_W,
    parameter int SENSOR_H = DEFAULT_SENSOR_H,
    parameter int MEM_AW   = $clog2(SENSOR_W * SENSOR_H)
) (
    input  logic [XY_BITS-1:0] x,
    input  logic [XY_BITS-1:0] y,
    output logic               in_bounds,
    output logic [MEM_AW-1:0]  addr
);

    logic [31:0] x_ext;
    logic [31:0] y_ext;

    assign x_ext = 32'(x);
    assign y_ext = 32'(y);

    // Unsigned compare: wrapped negative coordinates land far above the frame.
    assign in_bounds = (x_ext < 32'(SENSOR_W)) && (y_ext < 32'(SENSOR_H));
    assign addr      = in_bounds ? MEM_AW'(flat_addr(x_ext, y_ext, 32'(SENSOR_W))) : '0;

endmodule

// File: rtl/patch_gather.sv
// rtl/patch_gather.sv - gathers neighbour timestamp pairs into one activation vector
module patch_gather
    import mlp_act_pkg::*;
#(
    parameter int CAVIAR_X_Y_BITS = 9,
    parameter int SENSOR_W        = DEFAULT_SENSOR_W,
    parameter int SENSOR_H        = DEFAULT_SENSOR_H,
    parameter int TS_BITS         = DEFAULT_TS_BITS,
    parameter int N_PAIRS         = 4,
    parameter int MEM_AW          = $clog2(SENSOR_W * SENSOR_H),
    parameter int SLOT_W          = $clog2(N_PAIRS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SLOT_W-1:0]            req_slot,
    input  logic [CAVIAR_X_Y_BITS-1:0]   addr1_x,
    input  logic [CAVIAR_X_Y_BITS-1:0]   addr1_y,
    input  logic [CAVIAR_X_Y_BITS-1:0]   addr2_x,
    input  logic [CAVIAR_X_Y_BITS-1:0]   addr2_y,
    output logic                         mem_en,
    output logic [MEM_AW-1:0]            mem_addr1,
    output logic [MEM_AW-1:0]            mem_addr2,
    input  logic [TS_BITS-1:0]           mem_rdata1,
    input  logic [TS_BITS-1:0]           mem_rdata2,
    output logic                         act_valid,
    input  logic                         act_ready,
    output logic [2*N_PAIRS*TS_BITS-1:0] act_data
);

    patch_gather_state_e state;

    logic [SLOT_W-1:0]  slot_q;
    logic               in1_q;
    logic               in2_q;
    logic [N_PAIRS-1:0] seen;
    logic [N_PAIRS-1:0] seen_next;
    logic               in1;
    logic               in2;
    logic [MEM_AW-1:0]  flat1;
    logic [MEM_AW-1:0]  flat2;

    bounds_flatten #(
        .XY_BITS  (CAVIAR_X_Y_BITS),
        .SENSOR_W (SENSOR_W),
        .SENSOR_H (SENSOR_H),
        .MEM_AW   (MEM_AW)
    ) u_bf1 (
        .x         (addr1_x),
        .y         (addr1_y),
        .in_bounds (in1),
        .addr      (flat1)
    );

    bounds_flatten #(
        .XY_BITS  (CAVIAR_X_Y_BITS),
        .SENSOR_W (SENSOR_W),
        .SENSOR_H (SENSOR_H),
        .MEM_AW   (MEM_AW)
    ) u_bf2 (
        .x         (addr2_x),
        .y         (addr2_y),
        .in_bounds (in2),
        .addr      (flat2)
    );

    // Ready is a function of state only, so no path from req_valid back to req_ready.
    assign req_ready = (state == COLLECT) && !rst;
    assign mem_en    = req_ready && req_valid;
    assign mem_addr1 = mem_en ? flat1 : '0;
    assign mem_addr2 = mem_en ? flat2 : '0;
    assign seen_next = seen | (N_PAIRS'(1) << slot_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            slot_q    <= '0;
            in1_q     <= 1'b0;
            in2_q     <= 1'b0;
            seen      <= '0;
            act_valid <= 1'b0;
            act_data  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (req_valid) begin
                        slot_q <= req_slot;
                        in1_q  <= in1;
                        in2_q  <= in2;
                        state  <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    act_data[(2 * int'(slot_q)) * TS_BITS +: TS_BITS] <=
                        in1_q ? mem_rdata1 : '0;
                    act_data[(2 * int'(slot_q) + 1) * TS_BITS +: TS_BITS] <=
                        in2_q ? mem_rdata2 : '0;
                    seen <= seen_next;
                    if (&seen_next) begin
                        state     <= PRESENT;
                        act_valid <= 1'b1;
                    end else begin
                        state <= COLLECT;
                    end
                end
                PRESENT: begin
                    // The word buffer is kept; only the mask restarts.
                    if (act_ready) begin
                        seen      <= '0;
                        act_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_patch_gather.sv
// tb/tb_patch_gather.sv - scoreboard bench for patch_gather
module tb_patch_gather;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_slot;
    logic [8:0]   addr1_x, addr1_y, addr2_x, addr2_y;
    logic         mem_en;
    logic [13:0]  mem_addr1, mem_addr2;
    logic [15:0]  mem_rdata1, mem_rdata2;
    logic         act_valid;
    logic         act_ready;
    logic [127:0] act_data;

    int passes = 0;
    int total  = 0;
    logic [127:0] exp_q[$];

    patch_gather dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_slot   (req_slot),
        .addr1_x    (addr1_x),
        .addr1_y    (addr1_y),
        .addr2_x    (addr2_x),
        .addr2_y    (addr2_y),
        .mem_en     (mem_en),
        .mem_addr1  (mem_addr1),
        .mem_addr2  (mem_addr2),
        .mem_rdata1 (mem_rdata1),
        .mem_rdata2 (mem_rdata2),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .act_data   (act_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: samples just after the falling edge.
    always @(negedge clk) begin
        #2;
        if (!rst && act_valid && act_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_vector: got %0h expected none", act_data);
            end else begin
                chk("act_vector", act_data, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the read is captured.
    task automatic send(input int slot, input int x1, input int y1, input int x2, input int y2,
                        input int d1, input int d2, input int ea1, input int ea2, input bit b2b);
        if (b2b) chk("req_ready_b2b", 128'(req_ready), 128'(1));
        else wait_ready();
        req_valid = 1'b1;
        req_slot  = 2'(slot);
        addr1_x   = 9'(x1);
        addr1_y   = 9'(y1);
        addr2_x   = 9'(x2);
        addr2_y   = 9'(y2);
        #1;
        chk("mem_en_accept", 128'(mem_en), 128'(1));
        chk("mem_addr1", 128'(mem_addr1), 128'(ea1));
        chk("mem_addr2", 128'(mem_addr2), 128'(ea2));
        @(posedge clk);
        @(negedge clk);
        mem_rdata1 = 16'(d1);
        mem_rdata2 = 16'(d2);
        if (!b2b) req_valid = 1'b0;
        #1;
        chk("req_ready_wait", 128'(req_ready), 128'(0));
        chk("mem_en_wait", 128'(mem_en), 128'(0));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b1; req_slot = '0; act_ready = 1'b1;
        addr1_x = 9'd10; addr1_y = 9'd20; addr2_x = 9'd11; addr2_y = 9'd20;
        mem_rdata1 = '0; mem_rdata2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_mem_en", 128'(mem_en), 128'(0));
        chk("rst_mem_addr1", 128'(mem_addr1), 128'(0));
        chk("rst_act_valid", 128'(act_valid), 128'(0));
        chk("rst_act_data", act_data, 128'(0));
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);

        // Words 0..3 from in-bounds / out-of-bounds pairs, then complete with slots 2,3.
        exp_q.push_back({16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA,
                         16'h0000, 16'h0000, 16'h5678, 16'h1234});
        send(0, 10, 20, 11, 20, 'h1234, 'h5678, 2570, 2571, 0);
        send(1, 509, 5, 130, 5, 'hFFFF, 'hFFFF, 0, 0, 0);
        chk("no_valid_partial", 128'(act_valid), 128'(0));
        send(2, 0, 0, 127, 127, 'hAAAA, 'hBBBB, 0, 16383, 0);
        send(3, 5, 1, 6, 1, 'hCCCC, 'hDDDD, 133, 134, 0);
        chk("valid_v1", 128'(act_valid), 128'(1));
        @(negedge clk);

        // Back-to-back full vector, slots out of order.
        exp_q.push_back({16'h3113, 16'h3003, 16'h2323, 16'h2222,
                         16'h0000, 16'h1111, 16'h0B0B, 16'h0A0A});
        wait_ready();
        send(3, 1, 0, 2, 0, 'h3003, 'h3113, 1, 2, 1);
        send(0, 0, 1, 1, 1, 'h0A0A, 'h0B0B, 128, 129, 1);
        send(2, 100, 50, 101, 50, 'h2222, 'h2323, 6500, 6501, 1);
        send(1, 3, 127, 200, 3, 'h1111, 'h9999, 16259, 0, 1);
        req_valid = 1'b0;
        chk("valid_after_4th", 128'(act_valid), 128'(1));
        @(negedge clk);

        // Backpressure.
        act_ready = 1'b0;
        exp_q.push_back({16'h0107, 16'h0106, 16'h0105, 16'h0104,
                         16'h0103, 16'h0102, 16'h0101, 16'h0100});
        send(0, 0, 0, 1, 0, 'h0100, 'h0101, 0, 1, 0);
        send(1, 2, 0, 3, 0, 'h0102, 'h0103, 2, 3, 0);
        send(2, 4, 0, 5, 0, 'h0104, 'h0105, 4, 5, 0);
        send(3, 6, 0, 7, 0, 'h0106, 'h0107, 6, 7, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 128'(act_valid), 128'(1));
            chk("bp_ready", 128'(req_ready), 128'(0));
            chk("bp_data", act_data,
                {16'h0107, 16'h0106, 16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100});
            @(negedge clk);
        end
        act_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_accept", 128'(req_ready), 128'(1));
        chk("valid_after_accept", 128'(act_valid), 128'(0));

        // Duplicate slot: only the latest write survives, mask unchanged.
        exp_q.push_back({16'h4301, 16'h4300, 16'h7002, 16'h0002,
                         16'h4101, 16'h4100, 16'h4001, 16'h4000});
        send(2, 8, 2, 9, 2, 'h0001, 'h7001, 264, 265, 0);
        chk("dup_no_valid1", 128'(act_valid), 128'(0));
        send(2, 8, 2, 9, 2, 'h0002, 'h7002, 264, 265, 0);
        chk("dup_no_valid2", 128'(act_valid), 128'(0));
        send(0, 0, 9, 1, 9, 'h4000, 'h4001, 1152, 1153, 0);
        chk("dup_no_valid3", 128'(act_valid), 128'(0));
        send(1, 0, 10, 1, 10, 'h4100, 'h4101, 1280, 1281, 0);
        chk("dup_no_valid4", 128'(act_valid), 128'(0));
        send(3, 0, 11, 1, 11, 'h4300, 'h4301, 1408, 1409, 0);
        chk("dup_valid", 128'(act_valid), 128'(1));
        @(negedge clk);

        // Reset mid-collect, landing during WAIT_RD.
        send(0, 20, 0, 21, 0, 'h6000, 'h6001, 20, 21, 0);
        send(1, 22, 0, 23, 0, 'h6002, 'h6003, 22, 23, 0);
        wait_ready();
        req_valid = 1'b1; req_slot = 2'd2;
        addr1_x = 9'd1; addr1_y = 9'd1; addr2_x = 9'd2; addr2_y = 9'd1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; mem_rdata1 = 16'hEEEE; mem_rdata2 = 16'hEEEE;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mid_rst_req_ready", 128'(req_ready), 128'(0));
        chk("mid_rst_mem_en", 128'(mem_en), 128'(0));
        chk("mid_rst_mem_addr2", 128'(mem_addr2), 128'(0));
        chk("mid_rst_act_valid", 128'(act_valid), 128'(0));
        chk("mid_rst_act_data", act_data, 128'(0));
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        exp_q.push_back({16'h5004, 16'h5003, 16'h5008, 16'h5007,
                         16'h5002, 16'h5001, 16'h5006, 16'h5005});
        send(3, 12, 0, 13, 0, 'h5003, 'h5004, 12, 13, 0);
        send(2, 16, 0, 17, 0, 'h5007, 'h5008, 16, 17, 0);
        chk("post_rst_no_valid2", 128'(act_valid), 128'(0));
        send(1, 10, 0, 11, 0, 'h5001, 'h5002, 10, 11, 0);
        chk("post_rst_no_valid3", 128'(act_valid), 128'(0));
        send(0, 14, 0, 15, 0, 'h5005, 'h5006, 14, 15, 0);
        chk("post_rst_valid", 128'(act_valid), 128'(1));

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
